// File: rtl/result_capture.sv
// Captures the operation-sweep generator's result stream into a buffer, then replays it over valid/ready.
// Optional 16-bit rotate-xor signature of the stored samples when RESULT_CAPTURE_SIG_EN is defined.
module result_capture #(
    parameter int DEPTH      = 32,
    parameter int SKIP_FIRST = 1,
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW  = $clog2(DEPTH + 1),
    localparam int SKW = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_end,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [IW-1:0] rd_index,
    output logic          rd_last,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          overflow,
`ifdef RESULT_CAPTURE_SIG_EN
    output logic [15:0]   sig,
`endif
    output logic [1:0]    dbg_state
);

    // Handshake: an entry moves on every rising edge where rd_valid && rd_ready;
    // while rd_valid=1 and rd_ready=0, rd_data/rd_index/rd_last hold their values.

    typedef enum logic [1:0] {
        S_SKIP    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [SKW-1:0]   skip_cnt;
    logic [7:0]       mem [DEPTH];

    logic             full;
    logic             cap_store;
    logic             xfer;
    logic             drain_start;
    logic [IW-1:0]    next_index;
    logic [CW-1:0]    last_cnt;

    assign full        = (count == CW'(DEPTH));
    assign cap_store   = (state == S_CAPTURE) && !in_end && !full;
    assign xfer        = rd_valid && rd_ready;
    assign drain_start = (state == S_CAPTURE) && in_end && (count != '0);
    assign next_index  = rd_index + IW'(1);
    assign last_cnt    = count - CW'(1);

    assign done      = (state == S_FINISH);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (SKIP_FIRST == 0) state <= S_CAPTURE;
            else                 state <= S_SKIP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_SKIP: begin
                if (skip_cnt == SKW'(SKIP_FIRST - 1)) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (in_end) state_nx = (count == '0) ? S_FINISH : S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer && rd_last) state_nx = S_FINISH;
            end
            default: state_nx = S_FINISH;
        endcase
    end

    // Buffer contents survive reset; only the pointers and flags are cleared.
    always_ff @(posedge clk) begin
        if (cap_store) mem[count[IW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            rd_index <= '0;
            rd_last  <= 1'b0;
        end else begin
            if (state == S_SKIP) skip_cnt <= skip_cnt + SKW'(1);

            if (cap_store) count <= count + CW'(1);
            if ((state == S_CAPTURE) && !in_end && full) overflow <= 1'b1;

            // The first entry is preloaded on the edge that leaves CAPTURE.
            if (drain_start) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[0];
                rd_index <= '0;
                rd_last  <= (count == CW'(1));
            end else if ((state == S_DRAIN) && xfer) begin
                if (rd_last) begin
                    rd_valid <= 1'b0;
                end else begin
                    rd_data  <= mem[next_index];
                    rd_index <= next_index;
                    rd_last  <= (CW'(next_index) == last_cnt);
                end
            end
        end
    end

`ifdef RESULT_CAPTURE_SIG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= 16'h0000;
        end else if (cap_store) begin
            sig <= {sig[14:0], sig[15]} ^ {8'h00, in_data};
        end
    end
`endif

endmodule

// File: tb/tb_result_capture.sv
// Testbench for result_capture: scenario table on a DEPTH=32 and a DEPTH=4 instance,
// randomized sample data checked against a queue model of what should be stored and replayed.
module tb_result_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_end = 1'b0;
  logic       rd_ready = 1'b0;

  // DEPTH=32 instance
  logic       b_valid, b_last, b_done, b_ovf;
  logic [7:0] b_data;
  logic [4:0] b_index;
  logic [5:0] b_count;
  logic [1:0] b_state;
  // DEPTH=4 instance
  logic       s_valid, s_last, s_done, s_ovf;
  logic [7:0] s_data;
  logic [1:0] s_index;
  logic [2:0] s_count;
  logic [1:0] s_state;
`ifdef RESULT_CAPTURE_SIG_EN
  logic [15:0] b_sig, s_sig, m_sig;
`endif

  always #5 clk = ~clk;

  result_capture #(.DEPTH(32), .SKIP_FIRST(1)) u_big (
    .clk(clk), .rst(rst), .in_data(in_data), .in_end(in_end), .rd_ready(rd_ready),
    .rd_valid(b_valid), .rd_data(b_data), .rd_index(b_index), .rd_last(b_last),
    .count(b_count), .done(b_done), .overflow(b_ovf),
`ifdef RESULT_CAPTURE_SIG_EN
    .sig(b_sig),
`endif
    .dbg_state(b_state)
  );

  result_capture #(.DEPTH(4), .SKIP_FIRST(1)) u_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_end(in_end), .rd_ready(rd_ready),
    .rd_valid(s_valid), .rd_data(s_data), .rd_index(s_index), .rd_last(s_last),
    .count(s_count), .done(s_done), .overflow(s_ovf),
`ifdef RESULT_CAPTURE_SIG_EN
    .sig(s_sig),
`endif
    .dbg_state(s_state)
  );

  // Selected-instance view so one set of tasks serves both depths
  bit          sel = 1'b0;
  logic        m_valid, m_last, m_done, m_ovf;
  logic [31:0] m_data, m_index, m_count;

  always_comb begin
    m_valid = b_valid;
    m_last  = b_last;
    m_done  = b_done;
    m_ovf   = b_ovf;
    m_data  = 32'(b_data);
    m_index = 32'(b_index);
    m_count = 32'(b_count);
`ifdef RESULT_CAPTURE_SIG_EN
    m_sig   = b_sig;
`endif
    if (sel) begin
      m_valid = s_valid;
      m_last  = s_last;
      m_done  = s_done;
      m_ovf   = s_ovf;
      m_data  = 32'(s_data);
      m_index = 32'(s_index);
      m_count = 32'(s_count);
`ifdef RESULT_CAPTURE_SIG_EN
      m_sig   = s_sig;
`endif
    end
  end

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  typedef struct {
    bit sel;
    int n_cap;
    int ready_mode;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int abort_at;     // reset pulse after this many transfers, -1 for none
    bit no_reset;     // continue from the state left by a previous abort
    bit known;        // plant the reference data points of the sweep
    int exp_count;
    bit exp_ovf;
  } scen_t;

  scen_t tbl[9];

  task automatic run_scenario(input scen_t sc);
    logic [7:0]  samples[$];
    int          depth;
    int          xfers, cyc;
    bit          holding, aborted, rdy;
    logic [31:0] h_data, h_index, h_last;
    bit          pat[4];
    logic [15:0] sig_model;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sel = sc.sel;
    depth = sc.sel ? 4 : 32;

    samples.delete();
    for (int i = 0; i < sc.n_cap; i++) samples.push_back(8'($urandom_range(0, 255)));
    if (sc.known && sc.n_cap >= 24) begin
      samples[0]  = 8'h00; samples[1]  = 8'h02; samples[11] = 8'h0D;
      samples[14] = 8'h1E; samples[22] = 8'hA3; samples[23] = 8'hAA;
    end

    // Model: the first DEPTH samples are kept in order, anything beyond is lost
    exp_q.delete();
    sig_model = 16'h0000;
    for (int i = 0; i < sc.n_cap && i < depth; i++) begin
      exp_q.push_back(samples[i]);
      sig_model = {sig_model[14:0], sig_model[15]} ^ {8'h00, samples[i]};
    end

    rd_ready = 1'b0;
    if (!sc.no_reset) begin
      rst = 1'b1;
      @(negedge clk);
      check("rst_rd_valid", 32'(m_valid), 0);
      check("rst_rd_data",  m_data, 0);
      check("rst_rd_index", m_index, 0);
      check("rst_rd_last",  32'(m_last), 0);
      check("rst_count",    m_count, 0);
      check("rst_done",     32'(m_done), 0);
      check("rst_overflow", 32'(m_ovf), 0);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      @(negedge clk);
    end

    // Edge 1: generator fill cycle; in_end must be ignored here
    in_data = 8'($urandom_range(0, 255));
    in_end  = (sc.n_cap == 0);
    for (int i = 0; i < sc.n_cap; i++) begin
      @(negedge clk);
      in_data = samples[i];
      in_end  = 1'b0;
    end
    @(negedge clk);
    check("pre_end_done",  32'(m_done), 0);
    check("pre_end_valid", 32'(m_valid), 0);
    in_end  = 1'b1;
    in_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    check("cap_count",    m_count, 32'(sc.exp_count));
    check("cap_overflow", 32'(m_ovf), 32'(sc.exp_ovf));
    check("cap_done",     32'(m_done), 32'(exp_q.size() == 0));
`ifdef RESULT_CAPTURE_SIG_EN
    check("cap_sig", 32'(m_sig), 32'(sig_model));
`endif

    xfers = 0; cyc = 0; holding = 0; aborted = 0;
    h_data = 0; h_index = 0; h_last = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (sc.abort_at >= 0 && xfers == sc.abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_valid_drop", 32'(m_valid), 0);
        check("abort_count",      m_count, 0);
        check("abort_done",       32'(m_done), 0);
        #4 rst = 1'b0;
        rd_ready = 1'b0;
        aborted = 1;
        break;
      end
      case (sc.ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (holding) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data",  m_data, h_data);
        check("stall_index", m_index, h_index);
        check("stall_last",  32'(m_last), h_last);
      end
      if (m_valid) begin
        if (rdy) begin
          check("rd_data",  m_data, 32'(exp_q[0]));
          check("rd_index", m_index, 32'(xfers));
          check("rd_last",  32'(m_last), 32'(exp_q.size() == 1));
          void'(exp_q.pop_front());
          xfers++;
          holding = 0;
        end else begin
          holding = 1;
          h_data = m_data; h_index = m_index; h_last = 32'(m_last);
        end
      end
      rd_ready = rdy;
      cyc++;
      @(negedge clk);
    end

    if (!aborted) begin
      check("drain_timeout_left", 32'(exp_q.size()), 0);
      check("post_valid", 32'(m_valid), 0);
      check("post_done",  32'(m_done), 1);
      check("post_count", m_count, 32'(sc.exp_count));
      check("xfer_total", 32'(xfers), 32'(sc.exp_count));
      rd_ready = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("finish_hold_done",  32'(m_done), 1);
      check("finish_hold_valid", 32'(m_valid), 0);
    end
  endtask

  initial begin
    //            sel n_cap mode abort nores known cnt ovf
    tbl[0] = '{1'b0, 24, 0, -1, 1'b0, 1'b1, 24, 1'b0};
    tbl[1] = '{1'b0, 24, 1, -1, 1'b0, 1'b0, 24, 1'b0};
    tbl[2] = '{1'b1, 10, 0, -1, 1'b0, 1'b0,  4, 1'b1};
    tbl[3] = '{1'b0,  0, 0, -1, 1'b0, 1'b0,  0, 1'b0};
    tbl[4] = '{1'b0, 32, 2, -1, 1'b0, 1'b0, 32, 1'b0};
    tbl[5] = '{1'b0, 35, 2, -1, 1'b0, 1'b0, 32, 1'b1};
    tbl[6] = '{1'b1,  4, 1, -1, 1'b0, 1'b0,  4, 1'b0};
    tbl[7] = '{1'b0, 24, 0,  5, 1'b0, 1'b0, 24, 1'b0};
    tbl[8] = '{1'b0, 24, 0, -1, 1'b1, 1'b1, 24, 1'b0};

    for (int k = 0; k < 9; k++) run_scenario(tbl[k]);

`ifdef RESULT_CAPTURE_SIG_EN
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("sig_reset", 32'(m_sig), 0);
    rst = 1'b0;
    in_end = 1'b0;
    in_data = 8'hFF;
    @(negedge clk);
    check("sig_after_skip", 32'(m_sig), 0);
    in_data = 8'h01;
    @(negedge clk);
    check("sig_first", 32'(m_sig), 32'h0001);
    in_data = 8'h02;
    @(negedge clk);
    check("sig_second", 32'(m_sig), 32'h0000);
    in_end = 1'b1;
    in_data = 8'h55;
    @(negedge clk);
    check("sig_frozen", 32'(m_sig), 32'h0000);
    check("sig_count",  m_count, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
